hdmi_timing_gen: RTL and testbench
==================================

HDMI_TIMING_GEN -- requirements
Module: hdmi_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640: active pixels per line.
REQ-002 SHALL have parameters H_FP / H_SYNC / H_BP, defaults 16 / 96 / 48: horizontal front porch, sync and back porch, in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480: active lines per frame.
REQ-004 SHALL have parameters V_FP / V_SYNC / V_BP, defaults 10 / 2 / 33: vertical front porch, sync and back porch, in lines.
REQ-005 SHALL have parameters HS_POL / VS_POL, default 0 / 0: asserted sync level (0 = active-low).
REQ-006 SHALL have parameter LOOKAHEAD, default 2, legal range 1..8: cycles from coordinate request to pixel on the TX bus.
REQ-007 SHALL have parameters X_W / Y_W, defaults 10 / 9: coordinate widths; must satisfy 2^X_W >= H_ACTIVE and 2^Y_W >= V_ACTIVE.
REQ-008 SHALL have port clk, input, 1 bit: pixel clock; one clock only.
REQ-009 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-010 SHALL have port clk_en, input, 1 bit: advance enable; when low, all state holds.
REQ-011 SHALL have port mode, input, 2 bits: 0 = external color, 1 = color bars, 2 = grid, 3 = solid black.
REQ-012 SHALL have port color, input, 24 bits: external RGB {R,G,B} for the requested pixel.
REQ-013 SHALL have port pixel_x / pixel_y, output, X_W / Y_W bits: coordinate being requested.
REQ-014 SHALL have port pix_req, output, 1 bit: pixel_x/pixel_y name an active pixel.
REQ-015 SHALL have ports tx_de / tx_hs / tx_vs, output, 1 bit each: video data enable and syncs.
REQ-016 SHALL have port tx_d, output, 24 bits: RGB to the transmitter.
REQ-017 SHALL have port frame_start, output, 1 bit: one-cycle pulse on the TX-side cycle of pixel (0,0).

Function
REQ-018 SHALL run h_cnt over 0..H_TOTAL-1, where H_TOTAL = sum of the H parameters; v_cnt SHALL increment when h_cnt wraps and itself wrap at V_TOTAL-1; counters advance only when clk_en=1.
REQ-019 Order along each line and frame SHALL be active, front porch, sync, back porch; active region is h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
REQ-020 Sync assertion: hs SHALL be asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vs SHALL use the same rule on v_cnt, for whole lines.
REQ-021 Stage 0 (combinational from the counters) SHALL drive pixel_x=h_cnt and pixel_y=v_cnt when pix_req=1, else 0.
REQ-022 Alignment: de/hs/vs/pattern computed at stage 0 in cycle t SHALL appear on tx_* in cycle t+LOOKAHEAD, through a LOOKAHEAD-deep register pipeline gated by clk_en.
REQ-023 External color: in mode 0, color SHALL be sampled at the end of cycle t+LOOKAHEAD-1 and appear on tx_d in cycle t+LOOKAHEAD.
REQ-024 Mode 1 SHALL produce 8 equal vertical bars (bar k covers x in [k*H_ACTIVE/8, (k+1)*H_ACTIVE/8)), colored in order white, yellow, cyan, green, magenta, red, blue, black, with components 0xFF/0x00.
REQ-025 Mode 2 SHALL output 0xFFFFFF where x[3:0]==0 or y[3:0]==0, else 0x000000.
REQ-026 Mode 3 SHALL output 0x000000.
REQ-027 tx_d SHALL be 0x000000 whenever tx_de=0, in every mode.
REQ-028 mode SHALL be latched only at stage 0 when h_cnt=0, v_cnt=0 and clk_en=1; a mid-frame change takes effect on the next frame.
REQ-029 frame_start SHALL be asserted for exactly one clk_en-qualified cycle per frame, aligned with tx_de of pixel (0,0).
REQ-030 With clk_en held low, all outputs SHALL hold their values and no pulses may be generated or lost.

Reset
REQ-031 Asserting reset_n low SHALL immediately reset the following, at any time including mid-frame: h_cnt=v_cnt=0, pipeline cleared, latched mode=0.
REQ-032 Output values during reset SHALL be: tx_de=0, tx_hs=~HS_POL, tx_vs=~VS_POL, tx_d=0, frame_start=0, pixel_x=pixel_y=0, pix_req=1.
REQ-033 After release, the first clk_en cycle SHALL request (0,0); the TX side SHALL show blanking, inactive sync, for LOOKAHEAD cycles, then pixel (0,0) with frame_start=1.

Verification (H 8/2/2/2, V 4/1/1/1, LOOKAHEAD=2, clk_en=1 unless stated)
REQ-034 Mode 0 with color={8'h0,y,x}: release reset -> tx_de high 8 cycles per line starting cycle 2; tx_d[7:0] counts 0..7; tx_hs low at line cycles 10-11; tx_vs low for line 5; frame period 98 cycles.
REQ-035 Mode 1 -> active line reads FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000; porch cycles 000000.
REQ-036 Switch mode 0->2 at pixel (3,1) -> current frame stays external color; next frame's (0,0) is FFFFFF and (1,1) is 000000.
REQ-037 Toggle clk_en 1/0 alternately -> all outputs update only on enabled cycles; exactly one frame_start per 98 enabled cycles.
REQ-038 Assert reset_n at pixel (5,2) -> outputs take REQ-032 values asynchronously; after release, frame_start occurs 2 cycles later with a full 98-cycle frame following.

Source files
------------

// File: rtl/hdmi_timing_gen.sv
// Purpose: video timing generator producing coordinate requests and a TX pixel bus (de/hs/vs/rgb).
// Latency: stage 0 request -> TX outputs after LOOKAHEAD enabled cycles; external color sampled one cycle before TX.
// Backpressure: none; clk_en low freezes counters, pipeline and outputs.
// Ports: clk/reset_n/clk_en control; mode/color inputs select the pattern and supply external RGB;
//        pixel_x/pixel_y/pix_req name the requested pixel; tx_de/tx_hs/tx_vs/tx_d/frame_start drive the TX.
module hdmi_timing_gen #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic HS_POL    = 1'b0,
  parameter logic VS_POL    = 1'b0,
  parameter int   LOOKAHEAD = 2,
  parameter int   X_W       = 10,
  parameter int   Y_W       = 9
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clk_en,
  input  logic [1:0]     mode,
  input  logic [23:0]    color,
  output logic [X_W-1:0] pixel_x,
  output logic [Y_W-1:0] pixel_y,
  output logic           pix_req,
  output logic           tx_de,
  output logic           tx_hs,
  output logic           tx_vs,
  output logic [23:0]    tx_d,
  output logic           frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);

  logic [HC_W-1:0] h_cnt;
  logic [VC_W-1:0] v_cnt;
  logic [31:0]     h32, v32;
  logic            h_last, v_last;

  assign h32    = 32'(h_cnt);
  assign v32    = 32'(v_cnt);
  assign h_last = (h32 == H_TOTAL - 1);
  assign v_last = (v32 == V_TOTAL - 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (clk_en) begin
      h_cnt <= h_last ? '0 : h_cnt + 1'b1;
      if (h_last) begin
        v_cnt <= v_last ? '0 : v_cnt + 1'b1;
      end
    end
  end

  // Stage 0: everything derived combinationally from the counters.
  logic        de0, hs0, vs0, fs0, ext0;
  logic [1:0]  mode_q, mode_eff;
  logic [2:0]  bar;
  logic [23:0] pat0;

  // Pixel (0,0) already uses the incoming mode, which is latched for the rest of the frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= 2'd0;
    end else if (clk_en && fs0) begin
      mode_q <= mode;
    end
  end

  always_comb begin
    de0      = (h32 < H_ACTIVE) && (v32 < V_ACTIVE);
    hs0      = (h32 >= H_ACTIVE + H_FP) && (h32 < H_ACTIVE + H_FP + H_SYNC) ? HS_POL : ~HS_POL;
    vs0      = (v32 >= V_ACTIVE + V_FP) && (v32 < V_ACTIVE + V_FP + V_SYNC) ? VS_POL : ~VS_POL;
    fs0      = (h32 == 0) && (v32 == 0);
    mode_eff = fs0 ? mode : mode_q;
    bar      = 3'((h32 * 32'd8) / H_ACTIVE);
    ext0     = de0 && (mode_eff == 2'd0);
    pat0     = 24'h000000;
    if (de0) begin
      case (mode_eff)
        // Bar order white..black maps to R=~b[1], G=~b[2], B=~b[0].
        2'd1:    pat0 = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
        2'd2:    pat0 = (h32[3:0] == 4'd0 || v32[3:0] == 4'd0) ? 24'hFFFFFF : 24'h000000;
        default: pat0 = 24'h000000;
      endcase
    end
  end

  assign pix_req = de0;
  assign pixel_x = pix_req ? h32[X_W-1:0] : '0;
  assign pixel_y = pix_req ? v32[Y_W-1:0] : '0;

  // Alignment pipeline; entry LOOKAHEAD-1 drives the TX bus.
  logic [LOOKAHEAD-1:0] de_p, hs_p, vs_p, fs_p, ext_p;
  logic [23:0]          pat_p [LOOKAHEAD];
  logic [23:0]          color_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      de_p    <= '0;
      hs_p    <= {LOOKAHEAD{~HS_POL}};
      vs_p    <= {LOOKAHEAD{~VS_POL}};
      fs_p    <= '0;
      ext_p   <= '0;
      color_q <= 24'h000000;
      for (int i = 0; i < LOOKAHEAD; i++) pat_p[i] <= 24'h000000;
    end else if (clk_en) begin
      for (int i = LOOKAHEAD - 1; i > 0; i--) begin
        de_p[i]  <= de_p[i-1];
        hs_p[i]  <= hs_p[i-1];
        vs_p[i]  <= vs_p[i-1];
        fs_p[i]  <= fs_p[i-1];
        ext_p[i] <= ext_p[i-1];
        pat_p[i] <= pat_p[i-1];
      end
      de_p[0]  <= de0;
      hs_p[0]  <= hs0;
      vs_p[0]  <= vs0;
      fs_p[0]  <= fs0;
      ext_p[0] <= ext0;
      pat_p[0] <= pat0;
      // Sampled every enabled cycle; the value captured one cycle before the
      // pixel reaches TX is the external color answering that request.
      color_q  <= color;
    end
  end

  assign tx_de       = de_p[LOOKAHEAD-1];
  assign tx_hs       = hs_p[LOOKAHEAD-1];
  assign tx_vs       = vs_p[LOOKAHEAD-1];
  assign frame_start = fs_p[LOOKAHEAD-1];
  // ext_p is only set inside the active region, so blanking stays black.
  assign tx_d        = ext_p[LOOKAHEAD-1] ? color_q : pat_p[LOOKAHEAD-1];

endmodule

// File: tb/tb_hdmi_timing_gen.sv
module tb_hdmi_timing_gen;

  localparam int LA = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        clk_en = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [23:0] color = 24'h0;
  logic [3:0]  pixel_x;
  logic [2:0]  pixel_y;
  logic        pix_req, tx_de, tx_hs, tx_vs, frame_start;
  logic [23:0] tx_d;

  always #5 clk = ~clk;

  hdmi_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .LOOKAHEAD(LA), .X_W(4), .Y_W(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .mode(mode), .color(color),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .pix_req(pix_req),
    .tx_de(tx_de), .tx_hs(tx_hs), .tx_vs(tx_vs), .tx_d(tx_d), .frame_start(frame_start)
  );

  int          n_vec = 0;
  int          n_miss = 0;
  int          mh = 0, mv = 0;
  logic [1:0]  m_mode = 2'd0;
  logic        last_en = 1'b0;
  logic        count_fs = 1'b0;
  int          fs_seen = 0;
  logic [31:0] cur_exp;
  logic [31:0] expq[$];
  logic [23:0] colq[$];
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  // {de, hs, vs, frame_start, rgb} during reset / blanking before the first pixel
  localparam logic [31:0] RST_EXP = {4'h0, 1'b0, 1'b1, 1'b1, 1'b0, 24'h000000};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] tx_now();
    return {4'h0, tx_de, tx_hs, tx_vs, frame_start, tx_d};
  endfunction

  function automatic logic [31:0] coord_now();
    return {24'h0, pix_req, pixel_y, pixel_x};
  endfunction

  function automatic logic [31:0] coord_exp();
    logic pr;
    pr = (mh < 8) && (mv < 4);
    return {24'h0, pr, pr ? 3'(mv) : 3'd0, pr ? 4'(mh) : 4'd0};
  endfunction

  function automatic logic [31:0] exp_of(input int h, input int v, input logic [1:0] m);
    logic        de;
    logic [23:0] d;
    de = (h < 8) && (v < 4);
    d  = 24'h000000;
    if (de) begin
      case (m)
        2'd0:    d = {8'h00, 8'(v), 8'(h)};
        2'd1:    d = bars[h];
        2'd2:    d = ((h % 16) == 0 || (v % 16) == 0) ? 24'hFFFFFF : 24'h000000;
        default: d = 24'h000000;
      endcase
    end
    return {4'h0, de, (h >= 10 && h < 12) ? 1'b0 : 1'b1, (v == 5) ? 1'b0 : 1'b1,
            (h == 0 && v == 0), d};
  endfunction

  // One clock: check what the last edge produced, then drive the next edge.
  task automatic step(input logic en_i, input logic [1:0] md_i);
    @(negedge clk);
    if (last_en && expq.size() > 0) cur_exp = expq.pop_front();
    if (last_en && count_fs && frame_start) fs_seen++;
    chk("tx", tx_now(), cur_exp);
    chk("coord", coord_now(), coord_exp());
    if (en_i) begin
      if (mh == 0 && mv == 0) m_mode = md_i;
      expq.push_back(exp_of(mh, mv, m_mode));
      // External source answers each request one enabled cycle later.
      if (colq.size() > 0) color = colq.pop_front();
      colq.push_back({8'h00, 8'(mv), 8'(mh)});
      if (mh == 13) begin
        mh = 0;
        mv = (mv == 6) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end
    clk_en  = en_i;
    mode    = md_i;
    last_en = en_i;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clk_en  = 1'b0;
    #1;
    chk("rst_tx", tx_now(), RST_EXP);
    chk("rst_coord", coord_now(), 32'h80);
    repeat (2) begin
      @(negedge clk);
      chk("rst_tx_hold", tx_now(), RST_EXP);
      chk("rst_coord_hold", coord_now(), 32'h80);
    end
    reset_n = 1'b1;
    mh = 0;
    mv = 0;
    m_mode = 2'd0;
    expq.delete();
    colq.delete();
    repeat (LA - 1) expq.push_back(RST_EXP);
    cur_exp = RST_EXP;
    last_en = 1'b0;
  endtask

  initial begin
    #2;
    do_reset();

    // External color, a little over one frame.
    repeat (110) step(1'b1, 2'd0);

    // Color bars for two frames.
    repeat (200) step(1'b1, 2'd1);

    // Mode 0 frame, switch to grid at (3,1); the change lands on the next frame.
    do step(1'b1, 2'd0); while (!(mh == 0 && mv == 0));
    do step(1'b1, 2'd0); while (!(mh == 3 && mv == 1));
    repeat (200) step(1'b1, 2'd2);

    // Alternating clk_en: exactly one frame_start per 98 enabled cycles.
    begin
      int en_cnt;
      logic en;
      en_cnt   = 0;
      en       = 1'b1;
      fs_seen  = 0;
      count_fs = 1'b1;
      while (en_cnt < 196) begin
        step(en, 2'd1);
        if (en) en_cnt++;
        en = ~en;
      end
      step(1'b0, 2'd1);
      count_fs = 1'b0;
      chk("fs_per_196_en", 32'(fs_seen), 32'd2);
    end

    // Random enable and mode traffic.
    repeat (150) step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));

    // Reset mid-frame at (5,2), then a full frame and more.
    do step(1'b1, 2'd0); while (!(mh == 5 && mv == 2));
    step(1'b1, 2'd0);
    do_reset();
    repeat (120) step(1'b1, 2'd0);
    step(1'b0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
